// File: rtl/vga_framebuffer_dfb.sv
// rtl/vga_framebuffer_dfb.sv - parametrised VGA framebuffer with double buffering and optional clear engine
// Define FB_CLEAR_EN to build the back-buffer clear engine.
module vga_framebuffer_dfb #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_FP     = 16,
  parameter int H_SP     = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 11,
  parameter int V_SP     = 2,
  parameter int V_BP     = 31,
  parameter int BPP      = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [10:0]    x,
  input  logic [10:0]    y,
  input  logic [BPP-1:0] pixel_color,
  input  logic           pixel_write,
  output logic           wr_ready,
  input  logic           dfb_en,
  input  logic           swap_req,
  output logic           swap_done,
  input  logic           clear_req,
  input  logic [BPP-1:0] clear_color,
  output logic           clear_busy,
  output logic           frame_start,
  output logic [7:0]     VGA_R,
  output logic [7:0]     VGA_G,
  output logic [7:0]     VGA_B,
  output logic           VGA_CLK,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_N,
  output logic           VGA_SYNC_N
);

  localparam int HTOTAL   = 2 * (H_ACTIVE + H_FP + H_SP + H_BP);
  localparam int VTOTAL   = V_ACTIVE + V_FP + V_SP + V_BP;
  localparam int HW       = $clog2(HTOTAL);
  localparam int VW       = $clog2(VTOTAL);
  localparam int NPIX     = H_ACTIVE * V_ACTIVE;
  localparam int LW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int AW       = LW + 1;
  localparam int C        = (BPP == 1) ? 1 : BPP / 3;
  localparam int HS_START = 2 * (H_ACTIVE + H_FP);
  localparam int HS_END   = 2 * (H_ACTIVE + H_FP + H_SP);
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SP;

  typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

  logic [HW-1:0]  h_count;
  logic [VW-1:0]  v_count;
  logic           end_of_line;
  logic           end_of_field;
  logic           blank;
  logic [BPP-1:0] rd_data;
  logic           blank_n_q;
  logic           front;
  swap_state_t    state, state_nxt;

  logic [BPP-1:0] mem [0:2*NPIX-1];
  logic [LW-1:0]  rd_lin;
  logic [AW-1:0]  rd_addr;
  logic [LW-1:0]  wr_lin;
  logic           wr_in_range;
  logic           ext_we;
  logic           back_sel;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [BPP-1:0] mem_wdata;

  assign end_of_line  = (32'(h_count) == HTOTAL - 1);
  assign end_of_field = (32'(v_count) == VTOTAL - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (end_of_line) begin
      h_count <= '0;
      v_count <= end_of_field ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign VGA_CLK     = h_count[0];
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_HS      = !((32'(h_count) >= HS_START) && (32'(h_count) < HS_END));
  assign VGA_VS      = !((32'(v_count) >= VS_START) && (32'(v_count) < VS_END));
  assign blank       = (32'(h_count) >= 2 * H_ACTIVE) || (32'(v_count) >= V_ACTIVE);
  assign frame_start = (h_count == '0) && (v_count == '0);
  assign VGA_BLANK_N = blank_n_q;

  // Each pixel spans two clk cycles; the word is latched on the second half.
  assign rd_lin  = LW'(v_count) * LW'(H_ACTIVE) + LW'(h_count >> 1);
  assign rd_addr = {rd_lin, front & dfb_en};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data   <= '0;
      blank_n_q <= 1'b0;
    end else if (h_count[0]) begin
      blank_n_q <= !blank;
      rd_data   <= blank ? '0 : mem[rd_addr];
    end
  end

  assign back_sel    = !front & dfb_en;
  assign wr_lin      = LW'(y) * LW'(H_ACTIVE) + LW'(x);
  assign wr_in_range = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
  assign ext_we      = pixel_write & wr_ready & wr_in_range;

`ifdef FB_CLEAR_EN
  logic           clear_busy_q;
  logic [LW-1:0]  clear_addr;
  logic [BPP-1:0] clear_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clear_busy_q <= 1'b0;
      clear_addr   <= '0;
      clear_val    <= '0;
    end else if (clear_busy_q) begin
      clear_addr <= clear_addr + 1'b1;
      if (clear_addr == LW'(NPIX - 1))
        clear_busy_q <= 1'b0;
    end else if (clear_req) begin
      clear_busy_q <= 1'b1;
      clear_addr   <= '0;
      clear_val    <= clear_color;
    end
  end

  assign clear_busy = clear_busy_q;
  assign wr_ready   = !clear_busy_q;
  assign mem_we     = clear_busy_q | ext_we;
  assign mem_waddr  = clear_busy_q ? {clear_addr, back_sel} : {wr_lin, back_sel};
  assign mem_wdata  = clear_busy_q ? clear_val : pixel_color;
`else
  logic unused_clear;

  assign unused_clear = ^{clear_req, clear_color};
  assign clear_busy   = 1'b0;
  assign wr_ready     = 1'b1;
  assign mem_we       = ext_we;
  assign mem_waddr    = {wr_lin, back_sel};
  assign mem_wdata    = pixel_color;
`endif

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // A pending swap waits for a field end with no clear running.
  always_comb begin
    state_nxt = state;
    swap_done = 1'b0;
    if (!dfb_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (swap_req)
            state_nxt = S_PENDING;
        end
        S_PENDING: begin
          if (end_of_line && end_of_field && !clear_busy) begin
            swap_done = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      front <= 1'b0;
    end else begin
      state <= state_nxt;
      if (swap_done)
        front <= !front;
    end
  end

  function automatic logic [7:0] expand(input logic [C-1:0] f);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[7-i] = f[C-1-(i % C)];
    return r;
  endfunction

  generate
    if (BPP == 1) begin : g_mono
      assign VGA_R = {8{rd_data[0]}};
      assign VGA_G = {8{rd_data[0]}};
      assign VGA_B = {8{rd_data[0]}};
    end else begin : g_color
      assign VGA_R = expand(rd_data[3*C-1:2*C]);
      assign VGA_G = expand(rd_data[2*C-1:C]);
      assign VGA_B = expand(rd_data[C-1:0]);
    end
  endgenerate

endmodule

// File: tb/tb_vga_framebuffer_dfb.sv
// tb/tb_vga_framebuffer_dfb.sv - directed self-checking bench for vga_framebuffer_dfb
// Small 8x4 raster at 6 bpp: HTOTAL=30 clk, VTOTAL=8 lines, frame=240 clk.
module tb_vga_framebuffer_dfb;

  localparam int HT = 30;
  localparam int VT = 8;

  logic        clk;
  logic        rst_n;
  logic [10:0] x;
  logic [10:0] y;
  logic [5:0]  pixel_color;
  logic        pixel_write;
  logic        wr_ready;
  logic        dfb_en;
  logic        swap_req;
  logic        swap_done;
  logic        clear_req;
  logic [5:0]  clear_color;
  logic        clear_busy;
  logic        frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  vga_framebuffer_dfb #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_FP(2), .H_SP(3), .H_BP(2),
    .V_FP(1), .V_SP(2), .V_BP(1), .BPP(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pixel_color(pixel_color),
    .pixel_write(pixel_write), .wr_ready(wr_ready), .dfb_en(dfb_en),
    .swap_req(swap_req), .swap_done(swap_done), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(clear_busy), .frame_start(frame_start),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int exp_h();
    return cyc % HT;
  endfunction

  function automatic int exp_v();
    return (cyc / HT) % VT;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_hv(input int h, input int v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      @(negedge clk);
      if (exp_h() == h && exp_v() == v) found = 1'b1;
    end
    if (!found) check("wait_hv_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_swap_done(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (swap_done) found = 1'b1;
    end
    if (!found) check("swap_done_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic check_pixel(input string tag, input int px, input int py, input logic [23:0] rgb);
    wait_hv(2 * px + 2, py);
    check(tag, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, rgb});
    check({tag, "_blank_n"}, {31'd0, VGA_BLANK_N}, 32'd1);
  endtask

  task automatic write_px(input int px, input int py, input logic [5:0] c);
    x = 11'(px);
    y = 11'(py);
    pixel_color = c;
    pixel_write = 1'b1;
    @(negedge clk);
    pixel_write = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  initial begin
    int cnt;
    int c0;
    int bad;
    int npx;
    logic [3:0] exp_t;

    rst_n = 1'b0; x = '0; y = '0; pixel_color = '0; pixel_write = 1'b0;
    dfb_en = 1'b0; swap_req = 1'b0; clear_req = 1'b0; clear_color = '0;
    repeat (3) @(negedge clk);

    check("rst_frame_start", {31'd0, frame_start}, 32'd1);
    check("rst_hs", {31'd0, VGA_HS}, 32'd1);
    check("rst_vs", {31'd0, VGA_VS}, 32'd1);
    check("rst_blank_n", {31'd0, VGA_BLANK_N}, 32'd0);
    check("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check("rst_sync_n", {31'd0, VGA_SYNC_N}, 32'd1);
    check("rst_swap_done", {31'd0, swap_done}, 32'd0);
    check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    rst_n = 1'b1;

    // HS low for h in [20,26), VS low for v in [5,7), frame_start only at h=0,v=0.
    for (int i = 0; i < 2 * HT * VT; i++) begin
      @(negedge clk);
      exp_t[3] = !(exp_h() >= 20 && exp_h() < 26);
      exp_t[2] = !(exp_v() >= 5 && exp_v() < 7);
      exp_t[1] = exp_h() % 2 == 1;
      exp_t[0] = exp_h() == 0 && exp_v() == 0;
      check("timing_hs_vs_clk_fs", {28'd0, VGA_HS, VGA_VS, VGA_CLK, frame_start}, {28'd0, exp_t});
    end

    write_px(3, 1, 6'b110100);
    write_px(0, 0, 6'b011011);
    check_pixel("rgb_110100", 3, 1, 24'hFF5500);
    check_pixel("rgb_011011", 0, 0, 24'h55AAFF);
    wait_hv(18, 1);
    check("blank_right_margin", {31'd0, VGA_BLANK_N}, 32'd0);

    write_px(0, 3, 6'b000101);
    x = 11'd8; y = 11'd2; pixel_color = 6'h3F; pixel_write = 1'b1;
    #1 check("oor_x_wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    x = 11'd0; y = 11'd4;
    #1 check("oor_y_wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    pixel_write = 1'b0;
    check_pixel("oor_x_no_alias", 0, 3, 24'h005555);
    check_pixel("oor_y_no_alias", 0, 0, 24'h55AAFF);

    write_px(5, 2, 6'h00);
    dfb_en = 1'b1;
    write_px(5, 2, 6'h3F);
    check_pixel("back_write_hidden", 5, 2, 24'h000000);
    wait_hv(0, 1);
    pulse_swap();
    repeat (3) @(negedge clk);
    swap_req = 1'b1;
    repeat (2) @(negedge clk);
    swap_req = 1'b0;
    wait_swap_done(2 * HT * VT);
    check("swap_at_field_end", 32'(exp_h() * 16 + exp_v()), 32'((HT - 1) * 16 + VT - 1));
    @(negedge clk);
    check("swap_done_one_cycle", {31'd0, swap_done}, 32'd0);
    check_pixel("after_swap_white", 5, 2, 24'hFFFFFF);
    cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      @(negedge clk);
      if (swap_done) cnt++;
    end
    check("absorbed_second_req", 32'(cnt), 32'd0);

    wait_hv(0, 1);
    pulse_swap();
    wait_hv(0, 3);
    dfb_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      @(negedge clk);
      if (swap_done) cnt++;
    end
    check("dfb_off_no_swap", 32'(cnt), 32'd0);
    check_pixel("dfb_off_shows_buf0", 5, 2, 24'h000000);
    wait_hv(0, 1);
    dfb_en = 1'b1;
    check_pixel("front_held", 5, 2, 24'hFFFFFF);

`ifdef FB_CLEAR_EN
    x = 11'd8; y = 11'd0; pixel_color = 6'h00; pixel_write = 1'b1;
    clear_color = 6'h3F; clear_req = 1'b1;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) clear_req = 1'b0;
      if (!wr_ready) cnt++;
      if (clear_busy) bad++;
    end
    pixel_write = 1'b0;
    check("clear_stall_cycles", 32'(cnt), 32'd32);
    check("clear_busy_cycles", 32'(bad), 32'd32);
    wait_hv(0, 1);
    pulse_swap();
    wait_swap_done(2 * HT * VT);
    bad = 0;
    npx = 0;
    for (int i = 0; i < HT * VT; i++) begin
      @(negedge clk);
      if (exp_v() < 4 && exp_h() >= 2 && exp_h() <= 16 && exp_h() % 2 == 0) begin
        npx++;
        if ({VGA_R, VGA_G, VGA_B} != 24'hFFFFFF || !VGA_BLANK_N) bad++;
      end
    end
    check("cleared_frame_pixels", 32'(npx), 32'd32);
    check("cleared_frame_white", 32'(bad), 32'd0);

    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_clear", {31'd0, clear_busy}, 32'd0);
    check("reset_mid_clear_ready", {31'd0, wr_ready}, 32'd1);
    rst_n = 1'b1;

    wait_hv(0, 1);
    pulse_swap();
    wait_hv(19, 7);
    clear_req = 1'b1;
    c0 = cyc;
    @(negedge clk);
    clear_req = 1'b0;
    wait_swap_done(3 * HT * VT);
    check("swap_deferred_by_clear", 32'(cyc - c0), 32'd250);
`else
    clear_req = 1'b1;
    clear_color = 6'h3F;
    @(negedge clk);
    clear_req = 1'b0;
    check("no_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("no_clear_ready", {31'd0, wr_ready}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
